// File: rtl/sram_device_model_if.sv
// ----------------------------------------------------------------------------
// sram_if
// Address and control pins of the 16-bit asynchronous SRAM interface. The
// data bus SRAM_DQ is bidirectional and stays a plain inout port on the device
// model so that tristate resolution happens on an ordinary net.
//
// Signals (all pin-level, active-low controls):
//   SRAM_ADDR  word address
//   SRAM_UB_N  high-byte enable [15:8]
//   SRAM_LB_N  low-byte enable  [7:0]
//   SRAM_WE_N  write enable
//   SRAM_CE_N  chip enable
//   SRAM_OE_N  output enable
//
// Modports:
//   master  SRAM controller side, drives every pin
//   slave   device side, observes every pin
// ----------------------------------------------------------------------------
interface sram_if #(
  parameter int ADDR_W = 18
) ();
  logic [ADDR_W-1:0] SRAM_ADDR;
  logic              SRAM_UB_N;
  logic              SRAM_LB_N;
  logic              SRAM_WE_N;
  logic              SRAM_CE_N;
  logic              SRAM_OE_N;

  modport master (
    output SRAM_ADDR,
    output SRAM_UB_N,
    output SRAM_LB_N,
    output SRAM_WE_N,
    output SRAM_CE_N,
    output SRAM_OE_N
  );

  modport slave (
    input SRAM_ADDR,
    input SRAM_UB_N,
    input SRAM_LB_N,
    input SRAM_WE_N,
    input SRAM_CE_N,
    input SRAM_OE_N
  );
endinterface

// File: rtl/sram_device_model.sv
// ----------------------------------------------------------------------------
// sram_device_model
// Clocked, synthesizable model of the board's 16-bit asynchronous SRAM chip,
// i.e. the device end of the SRAM pin interface. It sits opposite the SRAM
// controller in simulation or on-FPGA when the external chip is absent.
//
// - Byte-masked writes (UB_N / LB_N) land in an internal array.
// - Reads are fully pipelined with READ_LATENCY stages (1..4); one read may
//   issue per clock and words appear on consecutive cycles.
// - SRAM_DQ is only driven, byte by byte, while the pins request a read and
//   a valid word sits at the head of the pipeline.
// - The memory array is never cleared; contents survive reset.
//
// Optional feature: define SRAM_MODEL_CHECK_EN to build the sticky
// pin-protocol checker behind protocol_error. Without it protocol_error is
// tied low and no check logic exists.
//
// Ports:
//   clk             system clock, all state changes on posedge
//   rst             asynchronous, active-low reset
//   sram            address/control pins (sram_if.slave)
//   SRAM_DQ         bidirectional data bus
//   access_count    accepted accesses (writes + read issues), wraps at 16 bits
//   protocol_error  sticky pin-protocol violation flag
// ----------------------------------------------------------------------------
module sram_device_model #(
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 18,
  parameter int DEPTH_LOG2   = 10,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  sram_if.slave             sram,
  inout  wire  [DATA_W-1:0] SRAM_DQ,
  output logic [15:0]       access_count,
  output logic              protocol_error
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int HB    = DATA_W / 2;

  // Byte masks only make sense on a 16-bit bus, and the pipeline depth is
  // bounded so the head stage index stays meaningful.
  if (DATA_W != 16) begin : g_bad_data_w
    $error("sram_device_model: DATA_W must be 16");
  end
  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
    $error("sram_device_model: READ_LATENCY must be in 1..4");
  end
  if (DEPTH_LOG2 < 1 || DEPTH_LOG2 >= ADDR_W) begin : g_bad_depth
    $error("sram_device_model: DEPTH_LOG2 must be in 1..ADDR_W-1");
  end

  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2-1:0] idx;
  logic                  sel;
  logic                  wr_cyc;
  logic                  rd_issue;

  assign idx      = sram.SRAM_ADDR[DEPTH_LOG2-1:0];
  assign sel      = ~sram.SRAM_CE_N;
  // A write cycle takes precedence over OE_N.
  assign wr_cyc   = sel & ~sram.SRAM_WE_N;
  assign rd_issue = sel &  sram.SRAM_WE_N & ~sram.SRAM_OE_N;

  // Storage array: no reset, contents persist across rst.
  always_ff @(posedge clk) begin
    if (wr_cyc) begin
      if (~sram.SRAM_UB_N) mem[idx][DATA_W-1:HB] <= SRAM_DQ[DATA_W-1:HB];
      if (~sram.SRAM_LB_N) mem[idx][HB-1:0]      <= SRAM_DQ[HB-1:0];
    end
  end

  // Read pipeline. Valid bits are control and get reset; the data path is
  // free-running and captures every cycle so a read sees all writes up to the
  // previous edge.
  logic              vld_p     [READ_LATENCY];
  logic [DATA_W-1:0] rd_data_p [READ_LATENCY];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        vld_p[i] <= 1'b0;
      end
    end else begin
      // ---- stage p0: issue ----
      vld_p[0] <= rd_issue;
      // ---- stages p1..pN: shift one per clock; deselect makes a bubble ----
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_p[i] <= vld_p[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    // ---- stage p0: array lookup ----
    rd_data_p[0] <= mem[idx];
    // ---- stages p1..pN: data follows its valid bit ----
    for (int i = 1; i < READ_LATENCY; i++) begin
      rd_data_p[i] <= rd_data_p[i-1];
    end
  end

  // ---- output stage: combinational, contention-safe DQ gate ----
  logic              head_vld;
  logic [DATA_W-1:0] head_data;
  logic              drv_ok;
  logic              hi_en;
  logic              lo_en;

  assign head_vld  = vld_p[READ_LATENCY-1];
  assign head_data = rd_data_p[READ_LATENCY-1];
  // A head word whose gate is closed is simply lost; nothing re-presents it.
  assign drv_ok    = head_vld & sel & ~sram.SRAM_OE_N & sram.SRAM_WE_N;
  assign hi_en     = drv_ok & ~sram.SRAM_UB_N;
  assign lo_en     = drv_ok & ~sram.SRAM_LB_N;

  assign SRAM_DQ[DATA_W-1:HB] = hi_en ? head_data[DATA_W-1:HB] : {HB{1'bz}};
  assign SRAM_DQ[HB-1:0]      = lo_en ? head_data[HB-1:0]      : {HB{1'bz}};

  // Writes and read issues are mutually exclusive (WE_N decides), so the
  // counter never needs to step by two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      access_count <= 16'd0;
    end else if (wr_cyc | rd_issue) begin
      access_count <= access_count + 16'd1;
    end
  end

`ifdef SRAM_MODEL_CHECK_EN
  logic bus_fight;
  logic empty_write;
  logic aliased;
  logic violation;
  logic err_q;

  assign bus_fight   = ~sram.SRAM_WE_N & ~sram.SRAM_OE_N;
  assign empty_write = ~sram.SRAM_WE_N &  sram.SRAM_UB_N & sram.SRAM_LB_N;
  assign aliased     = |sram.SRAM_ADDR[ADDR_W-1:DEPTH_LOG2];
  assign violation   = sel & (bus_fight | empty_write | aliased);

  // Sticky until reset; the offending access itself still completes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if (violation) begin
      err_q <= 1'b1;
    end
  end

  assign protocol_error = err_q;
`else
  // Upper address bits only matter to the checker; they alias otherwise.
  logic addr_hi_unused;
  assign addr_hi_unused = |sram.SRAM_ADDR[ADDR_W-1:DEPTH_LOG2];

  assign protocol_error = 1'b0;
`endif

endmodule

// File: tb/tb_sram_device_model.sv
module tb_sram_device_model;

  localparam int AW = 18;

`ifdef SRAM_MODEL_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_if #(.ADDR_W(AW)) bus ();

  wire  [15:0] dq1;
  wire  [15:0] dq3;
  logic        tb_drv = 1'b0;
  logic [15:0] tb_wd  = 16'h0000;

  assign dq1 = tb_drv ? tb_wd : 16'hzzzz;
  assign dq3 = tb_drv ? tb_wd : 16'hzzzz;

  // Released bus bits read back as 1.
  for (genvar b = 0; b < 16; b++) begin : g_pu
    pullup pu1 (dq1[b]);
    pullup pu3 (dq3[b]);
  end

  logic [15:0] count1, count3;
  logic        err1, err3;

  sram_device_model #(.DATA_W(16), .ADDR_W(AW), .DEPTH_LOG2(10), .READ_LATENCY(1)) u_rl1 (
    .clk(clk), .rst(rst), .sram(bus), .SRAM_DQ(dq1),
    .access_count(count1), .protocol_error(err1)
  );

  sram_device_model #(.DATA_W(16), .ADDR_W(AW), .DEPTH_LOG2(10), .READ_LATENCY(3)) u_rl3 (
    .clk(clk), .rst(rst), .sram(bus), .SRAM_DQ(dq3),
    .access_count(count3), .protocol_error(err3)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: memory contents, a per-edge record of which edges issued
  // a read and what word they fetched, access count and sticky error.
  logic [15:0] mem_m [1024];
  bit          hv [64];
  logic [15:0] hd [64];
  int          edge_n = 100;
  int          cnt_m  = 0;
  bit          err_m  = 1'b0;

  // Word seen on DQ now for a device of latency rl: the read issued at edge
  // (last edge - rl + 1), gated per byte by the current pins; Z reads as 1.
  function automatic logic [15:0] exp_dq(input int rl);
    int h;
    logic [15:0] r;
    h = (edge_n - rl + 1) & 63;
    r = 16'hFFFF;
    if (tb_drv) begin
      r = tb_wd;
    end else if (hv[h] && !bus.SRAM_CE_N && !bus.SRAM_OE_N && bus.SRAM_WE_N) begin
      if (!bus.SRAM_UB_N) r[15:8] = hd[h][15:8];
      if (!bus.SRAM_LB_N) r[7:0]  = hd[h][7:0];
    end
    return r;
  endfunction

  task automatic model_edge();
    int e;
    logic [9:0] ix;
    edge_n++;
    e = edge_n & 63;
    hv[e] = 1'b0;
    ix = bus.SRAM_ADDR[9:0];
    if (!bus.SRAM_CE_N) begin
      if (!bus.SRAM_WE_N) begin
        if (!bus.SRAM_UB_N) mem_m[ix][15:8] = tb_wd[15:8];
        if (!bus.SRAM_LB_N) mem_m[ix][7:0]  = tb_wd[7:0];
        if (rst) cnt_m++;
      end else if (!bus.SRAM_OE_N && rst) begin
        hv[e] = 1'b1;
        hd[e] = mem_m[ix];
        cnt_m++;
      end
      if (rst && CHK &&
          ((!bus.SRAM_WE_N && !bus.SRAM_OE_N) ||
           (!bus.SRAM_WE_N && bus.SRAM_UB_N && bus.SRAM_LB_N) ||
           (bus.SRAM_ADDR[AW-1:10] != '0)))
        err_m = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic pins(input bit ce_n, input bit we_n, input bit oe_n,
                      input bit ub_n, input bit lb_n,
                      input logic [AW-1:0] a, input logic [15:0] wd);
    bus.SRAM_CE_N = ce_n;
    bus.SRAM_WE_N = we_n;
    bus.SRAM_OE_N = oe_n;
    bus.SRAM_UB_N = ub_n;
    bus.SRAM_LB_N = lb_n;
    bus.SRAM_ADDR = a;
    tb_wd  = wd;
    tb_drv = !we_n;
    #1;
  endtask

  task automatic idle();
    pins(1, 1, 1, 1, 1, '0, 16'h0000);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [15:0] wd, input bit ub_n, input bit lb_n);
    pins(0, 0, 1, ub_n, lb_n, a, wd);
    tick();
  endtask

  task automatic model_reset_clear();
    for (int i = 0; i < 64; i++) hv[i] = 1'b0;
    cnt_m = 0;
    err_m = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    @(negedge clk);
    rst = 1'b0;
    model_reset_clear();
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b1;
    #1;
    checks++; if (dq1 !== 16'hFFFF) begin errors++; $display("FAIL reset_dq1 got=%h want=ffff(Z)", dq1); end
    checks++; if (dq3 !== 16'hFFFF) begin errors++; $display("FAIL reset_dq3 got=%h want=ffff(Z)", dq3); end
    checks++; if (count1 !== 16'd0) begin errors++; $display("FAIL reset_cnt1 got=%0d want=0", count1); end
    checks++; if (count3 !== 16'd0) begin errors++; $display("FAIL reset_cnt3 got=%0d want=0", count3); end
    checks++; if (err1 !== 1'b0) begin errors++; $display("FAIL reset_err1 got=%b want=0", err1); end
    checks++; if (err3 !== 1'b0) begin errors++; $display("FAIL reset_err3 got=%b want=0", err3); end
  endtask

  task automatic test_preload();
    for (int i = 0; i < 1024; i++) wr(AW'(i), 16'($urandom), 0, 0);
    idle();
    checks++; if (count1 !== 16'd1024) begin errors++; $display("FAIL preload_cnt1 got=%0d want=1024", count1); end
    checks++; if (count3 !== 16'd1024) begin errors++; $display("FAIL preload_cnt3 got=%0d want=1024", count3); end
  endtask

  task automatic test_write_read();
    int c0;
    c0 = cnt_m;
    wr(18'h00002, 16'hBEEF, 0, 0);
    pins(0, 1, 0, 0, 0, 18'h00002, 16'h0000);
    checks++; if (dq1 !== 16'hFFFF) begin errors++; $display("FAIL wr_rd_pre dq1 got=%h want=ffff", dq1); end
    for (int t = 1; t <= 3; t++) begin
      tick();
      if (t == 1) begin
        checks++; if (dq1 !== 16'hBEEF) begin errors++; $display("FAIL wr_rd_dq1 got=%h want=beef", dq1); end
        checks++; if (count1 !== 16'(c0 + 2)) begin errors++; $display("FAIL wr_rd_cnt got=%0d want=%0d", count1, 16'(c0 + 2)); end
      end
      if (t == 3) begin
        checks++; if (dq3 !== 16'hBEEF) begin errors++; $display("FAIL wr_rd_dq3 got=%h want=beef", dq3); end
      end
      checks++; if (dq3 !== exp_dq(3)) begin errors++; $display("FAIL wr_rd_model3 t=%0d got=%h want=%h", t, dq3, exp_dq(3)); end
    end
    idle();
    checks++; if (dq1 !== 16'hFFFF) begin errors++; $display("FAIL wr_rd_idle dq1 got=%h want=ffff", dq1); end
  endtask

  task automatic test_byte_mask();
    wr(18'h00010, 16'h1234, 0, 0);
    wr(18'h00010, 16'hAB00, 0, 1);
    pins(0, 1, 0, 0, 0, 18'h00010, 16'h0000);
    for (int t = 1; t <= 3; t++) begin
      tick();
      if (t == 1) begin
        checks++; if (dq1 !== 16'hAB34) begin errors++; $display("FAIL mask_dq1 got=%h want=ab34", dq1); end
      end
    end
    checks++; if (dq3 !== 16'hAB34) begin errors++; $display("FAIL mask_dq3 got=%h want=ab34", dq3); end
    pins(0, 1, 0, 1, 0, 18'h00010, 16'h0000);
    checks++; if (dq1 !== 16'hFF34) begin errors++; $display("FAIL mask_ub_dq1 got=%h want=zz34", dq1); end
    checks++; if (dq3 !== 16'hFF34) begin errors++; $display("FAIL mask_ub_dq3 got=%h want=zz34", dq3); end
    tick();
    checks++; if (dq1 !== exp_dq(1)) begin errors++; $display("FAIL mask_ub_model1 got=%h want=%h", dq1, exp_dq(1)); end
    idle();
  endtask

  task automatic test_back_to_back();
    logic [15:0] w1 [4];
    logic [15:0] w3 [4];
    logic [AW-1:0] seq [4];
    wr(18'd4, 16'h1111, 0, 0);
    wr(18'd5, 16'h2222, 0, 0);
    seq[0] = 18'd4; seq[1] = 18'd5; seq[2] = 18'd4; seq[3] = 18'd4;
    w1[0] = 16'h1111; w1[1] = 16'h2222; w1[2] = 16'h1111; w1[3] = 16'h1111;
    w3[0] = 16'hFFFF; w3[1] = 16'hFFFF; w3[2] = 16'h1111; w3[3] = 16'h2222;
    for (int t = 0; t < 4; t++) begin
      pins(0, 1, 0, 0, 0, seq[t], 16'h0000);
      tick();
      checks++; if (dq1 !== w1[t]) begin errors++; $display("FAIL b2b_dq1 t=%0d got=%h want=%h", t, dq1, w1[t]); end
      checks++; if (dq3 !== w3[t]) begin errors++; $display("FAIL b2b_dq3 t=%0d got=%h want=%h", t, dq3, w3[t]); end
    end
    idle();
  endtask

  task automatic test_alias();
    wr(18'h00400, 16'h5555, 0, 0);
    checks++; if (err1 !== CHK) begin errors++; $display("FAIL alias_err1 got=%b want=%b", err1, CHK); end
    checks++; if (err3 !== CHK) begin errors++; $display("FAIL alias_err3 got=%b want=%b", err3, CHK); end
    pins(0, 1, 0, 0, 0, 18'h00000, 16'h0000);
    tick();
    checks++; if (dq1 !== 16'h5555) begin errors++; $display("FAIL alias_dq1 got=%h want=5555", dq1); end
    tick(); tick();
    checks++; if (dq3 !== 16'h5555) begin errors++; $display("FAIL alias_dq3 got=%h want=5555", dq3); end
    checks++; if (err1 !== err_m) begin errors++; $display("FAIL alias_err_sticky got=%b want=%b", err1, err_m); end
    idle();
  endtask

  task automatic test_reset_mid_read();
    pins(0, 1, 0, 0, 0, 18'h00002, 16'h0000);
    tick();
    rst = 1'b0;
    model_reset_clear();
    #1;
    checks++; if (dq3 !== 16'hFFFF) begin errors++; $display("FAIL rstmid_dq3 got=%h want=ffff", dq3); end
    checks++; if (count3 !== 16'd0) begin errors++; $display("FAIL rstmid_cnt3 got=%0d want=0", count3); end
    checks++; if (err3 !== 1'b0) begin errors++; $display("FAIL rstmid_err3 got=%b want=0", err3); end
    for (int t = 0; t < 2; t++) begin
      tick();
      checks++; if (dq3 !== 16'hFFFF) begin errors++; $display("FAIL rstmid_hold_dq3 t=%0d got=%h want=ffff", t, dq3); end
    end
    rst = 1'b1;
    #1;
    for (int t = 0; t < 3; t++) begin
      tick();
      checks++; if (dq3 !== exp_dq(3)) begin errors++; $display("FAIL rstmid_rel_dq3 t=%0d got=%h want=%h", t, dq3, exp_dq(3)); end
    end
    checks++; if (dq3 !== 16'hBEEF) begin errors++; $display("FAIL rstmid_persist got=%h want=beef", dq3); end
    checks++; if (count3 !== 16'd3) begin errors++; $display("FAIL rstmid_cnt_after got=%0d want=3", count3); end
    idle();
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    for (int n = 0; n < 300; n++) begin
      a = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 1023));
      pins(($urandom_range(0, 4) == 0), $urandom_range(0, 1), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), a, 16'($urandom));
      if (!tb_drv) begin
        checks++; if (dq1 !== exp_dq(1)) begin errors++; $display("FAIL rand_dq1 n=%0d got=%h want=%h", n, dq1, exp_dq(1)); end
        checks++; if (dq3 !== exp_dq(3)) begin errors++; $display("FAIL rand_dq3 n=%0d got=%h want=%h", n, dq3, exp_dq(3)); end
      end
      tick();
      checks++; if (count1 !== 16'(cnt_m)) begin errors++; $display("FAIL rand_cnt1 n=%0d got=%0d want=%0d", n, count1, 16'(cnt_m)); end
      checks++; if (count3 !== 16'(cnt_m)) begin errors++; $display("FAIL rand_cnt3 n=%0d got=%0d want=%0d", n, count3, 16'(cnt_m)); end
      checks++; if (err1 !== err_m) begin errors++; $display("FAIL rand_err1 n=%0d got=%b want=%b", n, err1, err_m); end
      checks++; if (err3 !== err_m) begin errors++; $display("FAIL rand_err3 n=%0d got=%b want=%b", n, err3, err_m); end
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_preload();
    test_write_read();
    test_byte_mask();
    test_back_to_back();
    test_alias();
    test_reset_mid_read();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
